// File: rtl/csr_spmv_engine.sv
// CSR sparse-matrix x dense-vector engine: walks row pointers, column indices and values,
// multiply-accumulates each row and queues {row, sum} results. Optional macro: SPMV_ZERO_SKIP_EN.
module csr_spmv_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ACC_W      = 64,
  parameter int ROW_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] row_ptr_base,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [ADDR_W-1:0] val_base,
  input  logic [ADDR_W-1:0] vec_base,
  output logic              busy,
  output logic              done,
  output logic              a_req,
  output logic [ADDR_W-1:0] a_addr,
  input  logic              a_rvalid,
  input  logic [DATA_W-1:0] a_rdata,
  output logic              b_req,
  output logic [ADDR_W-1:0] b_addr,
  input  logic              b_rvalid,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [ROW_W-1:0]  res_row,
  output logic [2:0]        dbg_state_o
);

  // Read ports: req stays high with a stable addr until rvalid is seen high on a rising
  // edge (same-cycle rvalid allowed); rdata is captured on that edge and req may drop the
  // next cycle. One outstanding read per port; rvalid with req low is ignored.
  // Result stream: an entry transfers on any edge where res_valid & res_ready.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PTR0 = 3'd1,
    S_PTRN = 3'd2,
    S_NZ   = 3'd3,
    S_VEC  = 3'd4,
    S_EMIT = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [DATA_W-1:0] DATA_ONE  = 1;
  localparam logic [ROW_W-1:0]  ROW_ONE   = 1;
  localparam logic [PTR_W:0]    PTR_ONE   = 1;
  localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  state_t state_q, state_d;

  logic [ROW_W-1:0]  num_rows_q, row_q;
  logic [ADDR_W-1:0] row_ptr_base_q, col_base_q, val_base_q, vec_base_q;
  logic [DATA_W-1:0] k_q, k_end_q, col_q, mval_q;
  logic [ACC_W-1:0]  acc_q;
  logic              col_got_q, mval_got_q;

  logic              a_fire, b_fire, nz_done, push, pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] k_inc;
  logic [ROW_W-1:0]  row_inc;
  logic [ACC_W-1:0]  mac_prod;
`ifdef SPMV_ZERO_SKIP_EN
  logic [DATA_W-1:0] mval_cur;
`endif

  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic [ACC_W-1:0]  fifo_data_mem [FIFO_DEPTH];
  logic [ROW_W-1:0]  fifo_row_mem  [FIFO_DEPTH];

  assign a_fire   = a_req & a_rvalid;
  assign b_fire   = b_req & b_rvalid;
  assign nz_done  = (state_q == S_NZ) & (col_got_q | a_fire) & (mval_got_q | b_fire);
  assign k_inc    = k_q + DATA_ONE;
  assign row_inc  = row_q + ROW_ONE;
  assign mac_prod = ACC_W'(mval_q) * ACC_W'(b_rdata);
`ifdef SPMV_ZERO_SKIP_EN
  assign mval_cur = mval_got_q ? mval_q : b_rdata;
`endif

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == DEPTH_CNT);
  assign push       = (state_q == S_EMIT) & ~fifo_full;
  assign pop        = res_valid & res_ready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (num_rows == '0) ? S_FIN : S_PTR0;
      S_PTR0: if (a_fire) state_d = S_PTRN;
      S_PTRN: if (a_fire) state_d = (k_q == a_rdata) ? S_EMIT : S_NZ;
      S_NZ: begin
        if (nz_done) begin
`ifdef SPMV_ZERO_SKIP_EN
          if (mval_cur == '0) state_d = (k_inc == k_end_q) ? S_EMIT : S_NZ;
          else                state_d = S_VEC;
`else
          state_d = S_VEC;
`endif
        end
      end
      S_VEC:  if (b_fire) state_d = (k_inc == k_end_q) ? S_EMIT : S_NZ;
      S_EMIT: if (push) state_d = (row_inc == num_rows_q) ? S_FIN : S_PTRN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    a_req  = 1'b0;
    a_addr = '0;
    b_req  = 1'b0;
    b_addr = '0;
    case (state_q)
      S_PTR0: begin
        busy   = 1'b1;
        a_req  = 1'b1;
        a_addr = row_ptr_base_q;
      end
      S_PTRN: begin
        busy   = 1'b1;
        a_req  = 1'b1;
        a_addr = row_ptr_base_q + ADDR_W'(row_q) + ADDR_ONE;
      end
      S_NZ: begin
        busy = 1'b1;
        if (!col_got_q) begin
          a_req  = 1'b1;
          a_addr = col_base_q + ADDR_W'(k_q);
        end
        if (!mval_got_q) begin
          b_req  = 1'b1;
          b_addr = val_base_q + ADDR_W'(k_q);
        end
      end
      S_VEC: begin
        busy   = 1'b1;
        b_req  = 1'b1;
        b_addr = vec_base_q + ADDR_W'(col_q);
      end
      S_EMIT: busy = 1'b1;
      S_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      num_rows_q     <= '0;
      row_q          <= '0;
      row_ptr_base_q <= '0;
      col_base_q     <= '0;
      val_base_q     <= '0;
      vec_base_q     <= '0;
      k_q            <= '0;
      k_end_q        <= '0;
      col_q          <= '0;
      mval_q         <= '0;
      acc_q          <= '0;
      col_got_q      <= 1'b0;
      mval_got_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_rows_q     <= num_rows;
            row_ptr_base_q <= row_ptr_base;
            col_base_q     <= col_base;
            val_base_q     <= val_base;
            vec_base_q     <= vec_base;
            row_q          <= '0;
          end
        end
        S_PTR0: if (a_fire) k_q <= a_rdata;
        S_PTRN: begin
          if (a_fire) begin
            k_end_q    <= a_rdata;
            acc_q      <= '0;
            col_got_q  <= 1'b0;
            mval_got_q <= 1'b0;
          end
        end
        S_NZ: begin
          if (a_fire) begin
            col_q     <= a_rdata;
            col_got_q <= 1'b1;
          end
          if (b_fire) begin
            mval_q     <= b_rdata;
            mval_got_q <= 1'b1;
          end
          // Flags re-arm on exit so the next nonzero issues both reads again.
          if (nz_done) begin
            col_got_q  <= 1'b0;
            mval_got_q <= 1'b0;
`ifdef SPMV_ZERO_SKIP_EN
            if (mval_cur == '0) k_q <= k_inc;
`endif
          end
        end
        S_VEC: begin
          if (b_fire) begin
            acc_q <= acc_q + mac_prod;
            k_q   <= k_inc;
          end
        end
        S_EMIT: begin
          if (push) begin
            k_q   <= k_end_q;
            row_q <= row_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Result FIFO: pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_q[PTR_W-1:0]] <= acc_q;
      fifo_row_mem[wr_ptr_q[PTR_W-1:0]]  <= row_q;
    end
  end

  assign res_valid   = ~fifo_empty;
  assign res_data    = fifo_empty ? '0 : fifo_data_mem[rd_ptr_q[PTR_W-1:0]];
  assign res_row     = fifo_empty ? '0 : fifo_row_mem[rd_ptr_q[PTR_W-1:0]];
  assign dbg_state_o = state_q;

endmodule

// File: doc/csr_spmv_engine.md
Name: csr_spmv_engine

Overview:
Parametrised successor to the HHT control/fetch block. Walks a CSR sparse matrix (row pointers, column indices, values) and a dense vector through two independent read ports, multiply-accumulates each row, and emits per-row results through a buffered valid/ready stream. Sits between the CPU-programmed base registers and the HHT memory/buffer subsystem. Generalised in data/address width, accumulator width, row count and result-buffer depth.

Parameters:
DATA_W, 32, width of matrix values, vector values, row pointers and column indices
ADDR_W, 32, word address width of both read ports
ACC_W, 64, accumulator and result width (ACC_W >= DATA_W)
ROW_W, 16, width of num_rows and the row index
FIFO_DEPTH, 4, result buffer entries (power of 2, >= 2)

Ports:
Clk  in  1  clock; all logic on rising edge
Rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle launch pulse; ignored unless idle
num_rows  in  ROW_W  rows to process, sampled on start
row_ptr_base  in  ADDR_W  row pointer array base, sampled on start
col_base  in  ADDR_W  column index array base, sampled on start
val_base  in  ADDR_W  matrix value array base, sampled on start
vec_base  in  ADDR_W  dense vector base, sampled on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last result enters the FIFO
a_req  out  1  port A read request (row_ptr, col_idx)
a_addr  out  ADDR_W  port A address, stable while a_req high
a_rvalid  in  1  port A data valid
a_rdata  in  DATA_W  port A read data
b_req  out  1  port B read request (matrix value, vector)
b_addr  out  ADDR_W  port B address
b_rvalid  in  1  port B data valid
b_rdata  in  DATA_W  port B read data
res_valid  out  1  result available (FIFO not empty)
res_ready  in  1  consumer accepts on res_valid & res_ready
res_data  out  ACC_W  row dot product
res_row  out  ROW_W  row index of res_data

Behaviour:
- Reset: state IDLE; busy, done, a_req, b_req, res_valid = 0; a_addr, b_addr, res_data, res_row = 0; FIFO emptied; accumulator and counters cleared. Reset mid-operation aborts immediately; in-flight responses after reset are ignored.
- Read handshake, both ports: req held high with stable addr until rvalid is sampled high; rdata captured on that edge; req may fall the next cycle. rvalid may assert in the same cycle as req (zero-wait memory). rvalid while req low is ignored. At most one outstanding read per port.
- FSM states: IDLE, PTR0, PTRN, NZ, VEC, EMIT, FIN.
- IDLE: on start, latch inputs, row = 0; if num_rows == 0 go to FIN, else PTR0.
- PTR0: read A[row_ptr_base] -> k.
- PTRN: read A[row_ptr_base + row + 1] -> k_end; acc = 0; if k == k_end go to EMIT (empty row, result 0), else NZ.
- NZ: concurrently read A[col_base + k] -> col and B[val_base + k] -> mval; leave once both are captured, in either order. Go to VEC.
- VEC: read B[vec_base + col]; acc += mval * vdata (unsigned, product truncated to ACC_W, accumulation wraps modulo 2^ACC_W); k++; go to NZ if k != k_end, else EMIT.
- EMIT: push {row, acc} when FIFO not full, otherwise stall without issuing reads. After push: k = k_end; row++; PTRN if row != num_rows, else FIN.
- FIN: done = 1 for one cycle; busy = 0; return to IDLE. Undrained FIFO results remain valid.
- FIFO: first-word-fall-through; res_data/res_row reflect the head entry. Simultaneous push and pop when full is not possible, since EMIT waits for not-full. Push and pop in the same cycle otherwise keeps the count constant.
- Address arithmetic wraps modulo 2^ADDR_W. Row pointers are not range-checked; k_end < k behaves as a wrapping count.
- start while busy: ignored.

Optional Feature:
SPMV_ZERO_SKIP_EN: when defined, NZ with mval == 0 skips VEC (no port B vector read, acc unchanged, k++ and go to NZ or EMIT as usual). When undefined, every nonzero entry performs the vector read and MAC, including mval == 0.

Test Plan:
- num_rows=2, row_ptr={0,2,3}, col={1,0,2}, val={3,4,5}, vec={7,8,9}, zero-wait memory, res_ready=1 -> results (row0, 52), (row1, 45), then done pulse; busy high throughout.
- row_ptr={0,0,1}, col={0}, val={6}, vec={10} -> (row0, 0) with no NZ reads, then (row1, 60).
- Same as first case with random 0-3 cycle rvalid delays on each port, and port B answering before port A in NZ -> identical results; addresses stable while req is high.
- FIFO_DEPTH=4, num_rows=6, res_ready=0 -> 4 results buffered, FSM stalls in EMIT with no reads issued; raising res_ready drains all 6 in row order; done after the 6th push.
- Assert Rst while in VEC of row 1 -> all outputs zero in the same cycle; a new start then runs the first case correctly.
- val={0,4,5} with SPMV_ZERO_SKIP_EN defined -> row0=28 and 2 port B vector reads in total; with the macro undefined -> row0=28 and 3 vector reads.
